arbitro_pantalla: RTL and testbench
===================================

# arbitro_pantalla

Display arbiter and sequencer for the shared ILI9341 LCD path. It accepts redraw requests from up to four sources (base pet image, food animation, medicine animation, alert), each with its own 3-bit visualization code. It grants the screen to one source at a time, drives `visua` and a one-cycle `frame_start` to the LCD driver, and waits for `frame_done`. It then holds the image for a minimum dwell time before re-arbitrating. It sits between `Maquina_Estados_1`/`Modos` and `ili9341_top`.

## Interface
- `DWELL_CYCLES`, default 50_000_000: minimum cycles an image is held after `frame_done` (1 s at 50 MHz).
- `TIMEOUT_CYCLES`, default 10_000_000: maximum cycles to wait for `frame_done` before abandoning the draw.
- `clk`  in  1  system clock. One clock domain for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request lines, level-sensitive:
  - bit0 base image
  - bit1 comida
  - bit2 medicina
  - bit3 alerta
- `req_visua`  in  12  visualization codes; requester i owns bits [3i+2:3i].
- `frame_done`  in  1  one-cycle pulse from the LCD driver when a full frame has been written.
- `visua`  out  3  code currently driven to the LCD driver.
- `frame_start`  out  1  one-cycle pulse that starts a redraw.
- `grant`  out  4  one-hot grant; all zero when no source owns the screen.
- `busy`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  one-cycle pulse when a draw times out.

## Operation
- States are IDLE, START, DRAW and HOLD. State and all outputs are registered.
- Reset values: state IDLE, `visua`=3'b000, `grant`=4'b0000, `frame_start`=0, `busy`=0, `err_timeout`=0, round-robin pointer `rr`=0, counters 0. Reset asserted in any state takes effect at the next edge, with no completion of the current frame.
- Arbitration happens in IDLE, and for alert preemption in HOLD:
  - bit3 has fixed highest priority.
  - Among bits 2:0, round-robin. Search starts at `rr` and goes upward modulo 3.
  - After granting i in {0,1,2}, `rr` <= (i+1) mod 3. Alert grants leave `rr` unchanged.
- IDLE → START when any `req` bit is high. On that edge:
  - latch the winner's `req_visua` slice into `visua`;
  - set `grant` one-hot;
  - `frame_start` <= 1.
- IDLE with no request: stay. `visua` keeps its last value, because the screen retains the image.
- START → DRAW unconditionally. `frame_start` <= 0. The timeout counter clears.
- DRAW:
  - `frame_done` → HOLD, and the dwell counter clears.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES−1 without `frame_done`: `err_timeout` pulses, `grant` <= 0, go to IDLE.
  - If `frame_done` and the timeout occur on the same cycle, `frame_done` wins.
- HOLD:
  - The dwell counter counts 0..DWELL_CYCLES−1. On the terminal count: `grant` <= 0, go to IDLE.
  - The granted requester dropping `req` during HOLD does not shorten the dwell.
  - Preemption: if `req[3]`=1 and `grant[3]`=0, go directly to START with the alert code and `grant`=4'b1000, abandoning the remaining dwell.
- `req_visua` is sampled only at grant. Later changes on that slice are ignored until the next grant.
- Counter widths are $clog2 of their parameter and must never wrap inside a state.
- `frame_done` arriving outside DRAW is ignored.

## Timing
- Grant latency: a request seen in IDLE at edge k gives `grant`, `visua` and `frame_start`=1 valid in cycle k+1 (START). `frame_start` is exactly one cycle wide.
- Minimum screen ownership is 1 (START) + draw cycles (≥1) + DWELL_CYCLES.
- HOLD lasts exactly DWELL_CYCLES cycles. `grant` is zero for at least one IDLE cycle before the next non-preempting grant.
- Preemption: `req[3]` seen in HOLD at edge k gives alert `grant`/`visua` and `frame_start` in cycle k+1. There is no intermediate IDLE.
- `busy` equals (state != IDLE), registered with the state.

## Test plan
All scenarios use DWELL_CYCLES=8 and TIMEOUT_CYCLES=16.
- Reset then single request: `req`=4'b0010, codes bit1=3'd2. Expected:
  - next cycle `grant`=4'b0010, `visua`=2, `frame_start`=1 for 1 cycle;
  - `frame_done` 5 cycles later gives HOLD of exactly 8 cycles, then `grant`=0.
- Round-robin: hold `req`=4'b0111 continuously, with `frame_done` 3 cycles after each `frame_start`. Grant sequence must be 0001, 0010, 0100, 0001.
- Alert preemption: while `grant`=4'b0001 and HOLD at dwell count 3, pulse `req[3]` with code 3'd7. Next cycle `grant`=4'b1000, `visua`=7, `frame_start`=1. The next round-robin grant after the alert is 0010.
- Timeout: grant bit2 and never send `frame_done`. After 16 DRAW cycles, `err_timeout` pulses once, `grant`=0 and `busy`=0. Repeat with `frame_done` on the final cycle: HOLD is entered and there is no error.
- Reset mid-DRAW and mid-HOLD: assert `rst` for 1 cycle. Next cycle all outputs are at reset values and `rr`=0. A stray `frame_done` in IDLE has no effect.
- Request drop in HOLD: deassert `req[1]` right after `frame_done`. The dwell still completes with 8 HOLD cycles, and `visua` is unchanged after release.

Source files
------------

// File: rtl/arbitro_pantalla.sv
// Screen arbiter for the shared LCD path: grants one requester at a time, starts a
// frame, waits for completion (with timeout), then holds the image for a dwell period.
module arbitro_pantalla #(
    parameter int DWELL_CYCLES   = 50_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [11:0] req_visua,
    input  logic        frame_done,
    output logic [2:0]  visua,
    output logic        frame_start,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        err_timeout
);

    localparam int DCW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DCW-1:0] DWELL_LAST   = DCW'(DWELL_CYCLES - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DRAW, HOLD} state_t;

    state_t         state;
    logic [1:0]     rr;
    logic [DCW-1:0] dwell_cnt;
    logic [TCW-1:0] timeout_cnt;
    logic [1:0]     win;
    logic           win_vld;
    logic [2:0]     rr_hit;

    function automatic logic [1:0] mod3_add(input logic [1:0] base, input logic [1:0] ofs);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, ofs};
        mod3_add = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    // Returns {found, index}; scanning from the farthest offset down lets the
    // requester at rr itself overwrite any later match.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            idx = mod3_add(p, 2'(k));
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    function automatic logic [2:0] code_of(input logic [11:0] codes, input logic [1:0] idx);
        case (idx)
            2'd0:    code_of = codes[2:0];
            2'd1:    code_of = codes[5:3];
            2'd2:    code_of = codes[8:6];
            default: code_of = codes[11:9];
        endcase
    endfunction

    function automatic logic [1:0] next_rr(input logic [1:0] idx);
        next_rr = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        win     = 2'd3;
        win_vld = 1'b1;
        rr_hit  = rr_pick(req[2:0], rr);
        if (!req[3]) begin
            win     = rr_hit[1:0];
            win_vld = rr_hit[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            visua       <= 3'b000;
            grant       <= 4'b0000;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            rr          <= 2'd0;
            dwell_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            frame_start <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state       <= START;
                        busy        <= 1'b1;
                        frame_start <= 1'b1;
                        grant       <= 4'b0001 << win;
                        visua       <= code_of(req_visua, win);
                        if (win != 2'd3) rr <= next_rr(win);
                    end
                end
                START: begin
                    state       <= DRAW;
                    timeout_cnt <= '0;
                end
                DRAW: begin
                    // A completion on the timeout cycle still counts as a good frame.
                    if (frame_done) begin
                        state     <= HOLD;
                        dwell_cnt <= '0;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        grant       <= 4'b0000;
                        err_timeout <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (req[3] && !grant[3]) begin
                        state       <= START;
                        frame_start <= 1'b1;
                        grant       <= 4'b1000;
                        visua       <= req_visua[11:9];
                    end else if (dwell_cnt == DWELL_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        grant <= 4'b0000;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_pantalla.sv
// Scoreboard bench for arbitro_pantalla: the driver predicts grant/release events
// from the arbitration rules and cycle arithmetic; a monitor checks the DUT against them.
module tb_arbitro_pantalla;

    localparam int DW = 8;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_visua;
    logic        frame_done;
    logic [2:0]  visua;
    logic        frame_start;
    logic [3:0]  grant;
    logic        busy;
    logic        err_timeout;

    arbitro_pantalla #(.DWELL_CYCLES(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_visua(req_visua), .frame_done(frame_done),
        .visua(visua), .frame_start(frame_start), .grant(grant), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; logic [3:0] g; logic [2:0] v;} start_t;
    typedef struct {int c; logic err; logic [2:0] v;} end_t;

    start_t     exp_s[$];
    end_t       exp_e[$];
    int         passes = 0;
    int         checks = 0;
    int         rr_m   = 0;
    logic [2:0] last_v = 3'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    endtask

    // Reference arbitration: alert first, else first requester at or after rr (mod 3).
    function automatic int pick(input logic [3:0] r, input int p);
        if (r[3]) return 3;
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit scr, input bit alert, input bit in_draw, input bit done_now);
        if (scr) begin
            req       = {alert ? 1'($urandom) : 1'b0, 3'($urandom)};
            req_visua = 12'($urandom);
        end
        frame_done = in_draw ? done_now : 1'($urandom_range(0, 3) == 0);
    endtask

    task automatic run_to(input int x, input bit scr, input bit alert, input int s,
                          input int draw_last, input int done_at);
        while (cyc < x) begin
            drive(scr, alert, (cyc > s) && (cyc <= draw_last), cyc == done_at);
            tick();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req        = 4'b0000;
            frame_done = 1'($urandom_range(0, 2) == 0);
            tick();
        end
    endtask

    task automatic apply_reset();
        end_t e;
        e.c = cyc + 1; e.err = 1'b0; e.v = 3'd0;
        exp_e.push_back(e);
        rr_m   = 0;
        last_v = 3'd0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
    endtask

    // One ownership of the screen, starting from an IDLE cycle; may chain into an alert.
    task automatic txn(input logic [3:0] r, input logic [11:0] codes, input int j_in,
                       input int pre_h, input logic [2:0] pre_code, input int rmode,
                       input int roff, input bit scr);
        int w, s, j, h0, ph;
        bit alert, again;
        start_t st;
        end_t en;
        req = r; req_visua = codes; frame_done = 1'b0;
        w = pick(r, rr_m);
        st.c = cyc + 1; st.g = 4'(1 << w); st.v = codes[3*w +: 3];
        exp_s.push_back(st);
        last_v = st.v;
        if (w < 3) rr_m = (w + 1) % 3;
        alert = (w == 3); s = cyc + 1; j = j_in; ph = pre_h;
        tick();
        again = 1'b1;
        while (again) begin
            again = 1'b0;
            if (rmode == 1) begin
                run_to(s + roff, scr, alert, s, s + TO, -1);
                apply_reset();
            end else if (j > TO) begin
                en.c = s + TO + 1; en.err = 1'b1; en.v = last_v;
                exp_e.push_back(en);
                run_to(s + TO + 1, scr, alert, s, s + TO, -1);
            end else begin
                run_to(s + j + 1, scr, alert, s, s + j, s + j);
                h0 = s + j + 1;
                if (rmode == 2) begin
                    run_to(h0 + roff, scr, alert, s, s + j, -1);
                    apply_reset();
                end else if (ph >= 0 && !alert) begin
                    run_to(h0 + ph, scr, alert, s, s + j, -1);
                    drive(scr, alert, 1'b0, 1'b0);
                    req[3] = 1'b1;
                    req_visua[11:9] = pre_code;
                    st.c = cyc + 1; st.g = 4'b1000; st.v = pre_code;
                    exp_s.push_back(st);
                    last_v = pre_code;
                    alert = 1'b1; s = cyc + 1; j = $urandom_range(1, 6); ph = -1;
                    tick();
                    again = 1'b1;
                end else begin
                    en.c = h0 + DW; en.err = 1'b0; en.v = last_v;
                    exp_e.push_back(en);
                    run_to(h0 + DW, scr, alert, s, s + j, -1);
                end
            end
        end
    endtask

    // Monitor: frame_start and busy-falling events are matched against the queues.
    logic prev_fs = 1'b0;
    logic prev_busy = 1'b0;
    initial begin
        start_t st;
        end_t en;
        forever begin
            @(negedge clk);
            if (prev_fs === 1'b1) chk("frame_start_width", frame_start, 1'b0);
            if (frame_start === 1'b1) begin
                if (exp_s.size() == 0) chk("unexpected_frame_start", 1, 0);
                else begin
                    st = exp_s.pop_front();
                    chk("start_cycle", cyc, st.c);
                    chk("start_grant", grant, st.g);
                    chk("start_visua", visua, st.v);
                    chk("start_busy", busy, 1'b1);
                end
            end
            if (prev_busy === 1'b1 && busy === 1'b0) begin
                if (exp_e.size() == 0) chk("unexpected_release", 1, 0);
                else begin
                    en = exp_e.pop_front();
                    chk("release_cycle", cyc, en.c);
                    chk("release_grant", grant, 4'b0000);
                    chk("release_err", err_timeout, en.err);
                    chk("release_visua", visua, en.v);
                    chk("release_fs", frame_start, 1'b0);
                end
            end else if (err_timeout === 1'b1) begin
                chk("unexpected_err_timeout", 1, 0);
            end
            prev_fs   = frame_start;
            prev_busy = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d passed=%0d", checks, passes);
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        int j, ph, rm, ro;
        rst = 1'b1; req = 4'b0000; req_visua = 12'h000; frame_done = 1'b0;
        tick();
        tick();
        chk("reset_visua", visua, 3'b000);
        chk("reset_grant", grant, 4'b0000);
        chk("reset_frame_start", frame_start, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err", err_timeout, 1'b0);
        rst = 1'b0;
        idle(2);

        // Single request, then reset mid-DRAW, then round-robin with constant 0111.
        txn(4'b0010, 12'b000_000_010_000, 5, -1, 3'd0, 0, 0, 1'b0);
        idle(2);
        txn(4'b0111, 12'($urandom), 4, -1, 3'd0, 1, 3, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) txn(4'b0111, 12'o4321, 3, -1, 3'd0, 0, 0, 1'b0);
        idle(2);

        // Alert preempts at dwell count 3; round-robin resumes where it left off.
        txn(4'b0001, 12'o0005, 2, 3, 3'd7, 0, 0, 1'b0);
        txn(4'b0111, 12'o1234, 3, -1, 3'd0, 0, 0, 1'b0);
        idle(1);

        // Timeout, then frame_done on the last allowed DRAW cycle.
        txn(4'b0100, 12'o0600, TO + 1, -1, 3'd0, 0, 0, 1'b0);
        idle(1);
        txn(4'b0100, 12'o0300, TO, -1, 3'd0, 0, 0, 1'b0);
        idle(1);

        // Reset mid-HOLD, then a grant with requests and codes churning during ownership.
        txn(4'b0011, 12'o0012, 2, -1, 3'd0, 2, 4, 1'b0);
        idle(3);
        txn(4'b0010, 12'o0060, 3, -1, 3'd0, 0, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            r = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) != 0) r[3] = 1'b0;
            if (r == 4'b0000) r = 4'b0001;
            j  = ($urandom_range(0, 5) == 0) ? TO + 1 : $urandom_range(1, TO);
            ph = ($urandom_range(0, 2) == 0) ? $urandom_range(0, DW - 2) : -1;
            rm = 0; ro = 0;
            if ($urandom_range(0, 9) == 0) begin
                rm = $urandom_range(1, 2);
                ro = (rm == 1) ? $urandom_range(1, TO) : $urandom_range(0, DW - 1);
            end
            idle($urandom_range(0, 3));
            txn(r, 12'($urandom), j, ph, 3'($urandom), rm, ro, 1'b1);
        end

        idle(20);
        chk("leftover_starts", exp_s.size(), 0);
        chk("leftover_releases", exp_e.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
